// File: rtl/reg_wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl_pkg
// Shared constants and types for the register-file writeback controller:
// datapath width, register index width, RV32I load funct3 encodings and the
// writeback source selector.
// -----------------------------------------------------------------------------
package reg_wb_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Which producer owns the register-file write port this cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO holding ALU results ({rd, data}) while the load path owns
// the register-file write port. Combinational head read, registered count.
//   clk      : clock
//   rst      : asynchronous active-high reset (empties the FIFO)
//   push_i   : write wdata_i at the tail (ignored when full)
//   pop_i    : drop the head entry (ignored when empty)
//   wdata_i  : entry to push
//   rdata_o  : current head entry (valid when count_o != 0)
//   count_o  : occupancy after the most recent edge
// -----------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Full blocks a push even if the head pops in the same cycle.
    assign do_push = push_i && (count_q < FULL);
    assign do_pop  = pop_i  && (count_q != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are PTR_W bits wide, so wrap-around modulo DEPTH is free.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking (<=) so all flops update together at the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define validity, so stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl
// Drives the single register-file write port from the load-return path and the
// ALU path. Loads cannot stall, so they win; ALU results queue in wb_fifo and
// drain when the port is free, or bypass directly when the FIFO is empty.
//   clk, rst           : clock, asynchronous active-high reset
//   alu_valid/rd/data  : ALU result offer; alu_ready = FIFO not full
//   ld_valid/rd        : load return (always accepted)
//   ld_funct3/off/word : load type, byte offset, raw aligned memory word
//   RegWEn/AddrD/DataD : registered register-file write port
//   pend_cnt           : FIFO occupancy (registered)
// -----------------------------------------------------------------------------
module reg_wb_ctrl #(
    parameter int DEPTH = 2,
    parameter int XLEN  = reg_wb_ctrl_pkg::XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    output logic                   alu_ready,
    input  logic                   ld_valid,
    input  logic [4:0]             ld_rd,
    input  logic [2:0]             ld_funct3,
    input  logic [1:0]             ld_off,
    input  logic [XLEN-1:0]        ld_word,
    output logic                   RegWEn,
    output logic [4:0]             AddrD,
    output logic [XLEN-1:0]        DataD,
    output logic [$clog2(DEPTH):0] pend_cnt
);

    import reg_wb_ctrl_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Byte/half extraction with sign or zero extension. Halfword selection
    // uses only off[1]; misaligned offsets are not flagged.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            F3_LB:   return {{(XLEN-8){b[7]}}, b};
            F3_LH:   return {{(XLEN-16){h[15]}}, h};
            F3_LBU:  return {{(XLEN-8){1'b0}}, b};
            F3_LHU:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    logic [CNT_W-1:0]       count;
    logic [REG_W-1:0]       head_rd;
    logic [XLEN-1:0]        head_data;
    logic                   fifo_push, fifo_pop, alu_acc, ld_sel;
    wb_src_e                src;

    logic                   wen_q, wen_d;
    logic [REG_W-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]        data_q, data_d;

    assign alu_ready = (count < FULL);
    assign alu_acc   = alu_valid && alu_ready;
    assign ld_sel    = ld_valid && (ld_rd != '0);

    always_comb begin
        src = SRC_NONE;
        if (ld_sel)
            src = SRC_LOAD;
        else if (count != '0)
            src = SRC_FIFO;
        else if (alu_acc && (alu_rd != '0))
            src = SRC_ALU;
    end

    // An accepted beat with rd=0 is consumed silently; otherwise it is queued
    // unless the bypass took it this cycle.
    assign fifo_push = alu_acc && (alu_rd != '0) && (src != SRC_ALU);
    assign fifo_pop  = (src == SRC_FIFO);

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (REG_W + XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({alu_rd, alu_data}),
        .rdata_o ({head_rd, head_data}),
        .count_o (count)
    );

    // Address/data hold their last values when no write is selected.
    always_comb begin
        wen_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        case (src)
            SRC_LOAD: begin
                wen_d  = 1'b1;
                addr_d = ld_rd;
                data_d = load_extract(ld_funct3, ld_off, ld_word);
            end
            SRC_FIFO: begin
                wen_d  = 1'b1;
                addr_d = head_rd;
                data_d = head_data;
            end
            SRC_ALU: begin
                wen_d  = 1'b1;
                addr_d = alu_rd;
                data_d = alu_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign RegWEn   = wen_q;
    assign AddrD    = addr_q;
    assign DataD    = data_q;
    assign pend_cnt = count;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_ctrl
// Self-checking bench for reg_wb_ctrl. A small queue model of the arbitration
// and ALU FIFO predicts each cycle's write; predictions go to a scoreboard
// queue and are compared against the write port one edge later.
// -----------------------------------------------------------------------------
module tb_reg_wb_ctrl;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [4:0]        ld_rd;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_off;
    logic [XLEN-1:0]   ld_word;
    logic              RegWEn;
    logic [4:0]        AddrD;
    logic [XLEN-1:0]   DataD;
    logic [$clog2(DEPTH):0] pend_cnt;

    reg_wb_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_funct3 (ld_funct3),
        .ld_off    (ld_off),
        .ld_word   (ld_word),
        .RegWEn    (RegWEn),
        .AddrD     (AddrD),
        .DataD     (DataD),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t          sb[$];      // expected write-port activity, one per cycle
    logic [36:0]   mq[$];      // model of the ALU FIFO contents {rd, data}
    logic [4:0]    last_rd;    // write port holds these when idle
    logic [31:0]   last_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle. Called just after a rising edge; drives inputs,
    // predicts the outcome at the falling edge, checks just after next edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] word,
                        input logic [31:0] lexp, output logic acc);
        exp_t e;
        logic m_ready, bypassed;
        logic [36:0] head;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        ld_valid  = lv;  ld_rd  = lrd;  ld_funct3 = f3;  ld_off = off;  ld_word = word;
        @(negedge clk);
        m_ready = (mq.size() < DEPTH);
        check("alu_ready", {31'd0, alu_ready}, {31'd0, m_ready});
        acc = av && m_ready;
        bypassed = 1'b0;
        e.wen = 1'b0;  e.rd = last_rd;  e.data = last_data;
        if (lv && lrd != 5'd0) begin
            e.wen = 1'b1;  e.rd = lrd;  e.data = lexp;
        end else if (mq.size() > 0) begin
            head = mq.pop_front();
            e.wen = 1'b1;  e.rd = head[36:32];  e.data = head[31:0];
        end else if (acc && ard != 5'd0) begin
            e.wen = 1'b1;  e.rd = ard;  e.data = adat;  bypassed = 1'b1;
        end
        if (acc && ard != 5'd0 && !bypassed) mq.push_back({ard, adat});
        if (e.wen) begin
            last_rd = e.rd;  last_data = e.data;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("RegWEn", {31'd0, RegWEn}, {31'd0, e.wen});
        check("AddrD", {27'd0, AddrD}, {27'd0, e.rd});
        check("DataD", DataD, e.data);
        check("pend_cnt", {30'd0, pend_cnt}, mq.size());
    endtask

    task automatic idle();
        logic a;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'b010, 2'd0, 32'd0, 32'd0, a);
    endtask

    task automatic alu_only(input logic [4:0] rd, input logic [31:0] d);
        logic a;
        step(1'b1, rd, d, 1'b0, 5'd0, 3'b010, 2'd0, 32'd0, 32'd0, a);
    endtask

    task automatic load_only(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] word, input logic [31:0] exp);
        logic a;
        step(1'b0, 5'd0, 32'd0, 1'b1, rd, f3, off, word, exp, a);
    endtask

    initial begin
        logic        acc;
        logic [1:0]  nxt;
        int          cyc;
        logic [4:0]  rds [3];
        rds[0] = 5'd1;  rds[1] = 5'd2;  rds[2] = 5'd3;
        last_rd = 5'd0;  last_data = 32'd0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        alu_valid = 1'b0;  alu_rd = '0;  alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_funct3 = '0;  ld_off = '0;  ld_word = '0;
        #3;
        check("rst_RegWEn", {31'd0, RegWEn}, 32'd0);
        check("rst_AddrD", {27'd0, AddrD}, 32'd0);
        check("rst_DataD", DataD, 32'd0);
        check("rst_pend_cnt", {30'd0, pend_cnt}, 32'd0);
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        @(negedge clk);  @(negedge clk);
        rst = 1'b0;
        @(posedge clk);  #1;

        // ---------------- ALU bypass ----------------
        idle();
        alu_only(5'd5, 32'h0000_1234);
        idle();

        // ---------------- load priority with buffering ----------------
        step(1'b1, 5'd7, 32'h11, 1'b1, 5'd3, 3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, acc);
        check("prio_pend_after_load", {30'd0, pend_cnt}, 32'd1);
        idle();
        check("prio_x7_addr", {27'd0, AddrD}, 32'd7);
        idle();

        // ---------------- FIFO full backpressure ----------------
        nxt = 2'd0;
        cyc = 0;
        while ((cyc < 4 || nxt < 2'd3) && cyc < 20) begin
            if (cyc >= 2 && cyc <= 4)
                check("full_ready_low", {31'd0, alu_ready}, 32'd0);
            step(nxt < 2'd3, (nxt < 2'd3) ? rds[nxt] : 5'd0, 32'hA0 + 32'(nxt),
                 cyc < 4, 5'd20 + 5'(cyc), 3'b010, 2'd0, 32'h5000_0000 + 32'(cyc),
                 32'h5000_0000 + 32'(cyc), acc);
            if (acc && nxt == 2'd2) check("rd3_accept_cycle", cyc, 32'd5);
            if (acc) nxt = nxt + 2'd1;
            cyc++;
        end
        if (cyc >= 20) check("full_timeout", cyc, 32'd0);
        repeat (3) idle();

        // ---------------- load extraction ----------------
        load_only(5'd9,  3'b000, 2'd0, 32'h8180_7F80, 32'hFFFF_FF80);
        load_only(5'd10, 3'b100, 2'd0, 32'h8180_7F80, 32'h0000_0080);
        load_only(5'd11, 3'b000, 2'd1, 32'h8180_7F80, 32'h0000_007F);
        load_only(5'd12, 3'b001, 2'd2, 32'h8180_7F80, 32'hFFFF_8180);
        load_only(5'd13, 3'b101, 2'd2, 32'h8180_7F80, 32'h0000_8180);
        load_only(5'd14, 3'b001, 2'd0, 32'h8180_7F80, 32'h0000_7F80);
        load_only(5'd15, 3'b101, 2'd3, 32'h8180_7F80, 32'h0000_8180);
        load_only(5'd16, 3'b010, 2'd1, 32'h8180_7F80, 32'h8180_7F80);
        load_only(5'd17, 3'b111, 2'd0, 32'h8180_7F80, 32'h8180_7F80);

        // ---------------- x0 suppression ----------------
        step(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 3'b010, 2'd0, 32'hBAD1, 32'hBAD1, acc);
        check("x0_ready", {31'd0, alu_ready}, 32'd1);
        step(1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 3'b010, 2'd0, 32'h55, 32'h55, acc);
        step(1'b1, 5'd0, 32'hBAD2, 1'b1, 5'd0, 3'b010, 2'd0, 32'hBAD3, 32'hBAD3, acc);
        check("x0_head_drain_addr", {27'd0, AddrD}, 32'd6);
        idle();

        // ---------------- random mix (pointer wrap) ----------------
        for (int i = 0; i < 60; i++) begin
            logic [31:0] w;
            w = $urandom;
            step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), 3'b010, 2'd0, w, w, acc);
        end
        repeat (3) idle();

        // ---------------- reset mid-stream ----------------
        step(1'b1, 5'd10, 32'hC10, 1'b1, 5'd4, 3'b010, 2'd0, 32'h44, 32'h44, acc);
        step(1'b1, 5'd11, 32'hC11, 1'b1, 5'd8, 3'b010, 2'd0, 32'h88, 32'h88, acc);
        check("mid_pend_before_rst", {30'd0, pend_cnt}, 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_RegWEn", {31'd0, RegWEn}, 32'd0);
        check("mid_rst_pend_cnt", {30'd0, pend_cnt}, 32'd0);
        check("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        mq.delete();
        last_rd = 5'd0;  last_data = 32'd0;
        @(negedge clk);
        alu_valid = 1'b0;  ld_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);  #1;
        repeat (4) idle();

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Writeback controller that drives the single register-file write port (RegWEn/AddrD/DataD) from two producers: the single-cycle ALU path and the variable-latency load-return path.
- Arbitrates between the two producers and buffers ALU results in a small FIFO while load returns own the port.
- Performs load byte/half extraction with sign or zero extension, and suppresses writes to x0.
- Sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 2, ALU result FIFO entries (power of two, >=2)
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  FIFO can accept; combinational, equals (count < DEPTH)
- ld_valid  in  1  load data returning this cycle (cannot be stalled)
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type (RV32I encoding)
- ld_off  in  2  byte address bits [1:0]
- ld_word  in  XLEN  raw aligned memory word
- RegWEn  out  1  register-file write enable (registered)
- AddrD  out  5  write address (registered)
- DataD  out  XLEN  write data (registered)
- pend_cnt  out  $clog2(DEPTH)+1  FIFO occupancy (registered)

Behaviour:
- Reset: asynchronous; RegWEn=0, AddrD=0, DataD=0, FIFO emptied, pend_cnt=0. Entries held in the FIFO at reset are discarded.
- Latency: a selected write appears on RegWEn/AddrD/DataD one cycle after selection. RegWEn is a one-cycle pulse per write.
- Per-cycle selection priority:
  1. Load: ld_valid and ld_rd!=0.
  2. FIFO head: FIFO non-empty.
  3. Direct ALU bypass: alu_valid and alu_ready and FIFO empty and alu_rd!=0.
  4. Otherwise RegWEn=0 next cycle; AddrD/DataD hold their previous values.
- ALU acceptance: a beat is accepted when alu_valid and alu_ready.
  - If accepted, alu_rd!=0 and the beat is not taken by the bypass, it is pushed to the FIFO tail.
  - A beat is therefore pushed whenever a load or the FIFO head wins the cycle.
- rd=0 handling: an accepted ALU beat with rd=0 is consumed and dropped, with no push and no write. A load with ld_rd=0 is dropped, and the FIFO head may drain that cycle.
- alu_ready depends only on the current count. When full, no push occurs even if a pop happens in the same cycle.
- Simultaneous pop and push (non-full): count is unchanged and pointers wrap modulo DEPTH.
- Ordering:
  - FIFO preserves ALU order.
  - The bypass is used only when the FIFO is empty, so an ALU result never overtakes an older ALU result.
  - Load vs ALU ordering to the same rd is not resolved here. The hazard unit guarantees no two in-flight writes target the same rd.
- Load extraction (byte b = ld_word[8*ld_off+7 : 8*ld_off], half h = ld_word[16*ld_off[1]+15 : 16*ld_off[1]]):
  - 000 LB: sign-extend b
  - 001 LH: sign-extend h
  - 100 LBU: zero-extend b
  - 101 LHU: zero-extend h
  - 010 LW and all other encodings: ld_word unchanged
  - LH/LHU use only ld_off[1]. Misalignment is not flagged.
- pend_cnt reflects the occupancy after the current edge.

Decomposition:
- Shared package:
  - load funct3 constants: F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101
  - register index width constant (5)
  - XLEN
- One natural sub-module: wb_fifo, a synchronous FIFO with DEPTH entries of {rd[4:0], data[XLEN-1:0]}, push/pop/count, async active-high reset.
- The load extractor stays inline as a combinational function.

Test Plan:
- Reset mid-stream: push 2 ALU beats while ld_valid is held high, assert rst -> RegWEn=0, pend_cnt=0, alu_ready=1 immediately, no later write of either beat.
- ALU bypass: alu_valid, rd=5, data=0x0000_1234, FIFO empty -> next cycle RegWEn=1, AddrD=5, DataD=0x0000_1234.
- Load priority with buffering:
  - Cycle 0: ld_valid rd=3 LW word 0xDEADBEEF, plus alu_valid rd=7 data=0x11.
  - Expected: cycle 1 writes x3=0xDEADBEEF with pend_cnt=1; cycle 2 writes x7=0x11 with pend_cnt=0.
- FIFO full backpressure:
  - ld_valid held for 4 cycles while ALU offers rd=1,2,3.
  - Expected: alu_ready=0 after 2 accepts; drained in order x1 then x2 after the loads; rd=3 is accepted only once alu_ready returns high.
- Extraction, ld_word=0x8180_7F80:
  - LB off=0 -> 0xFFFF_FF80
  - LBU off=0 -> 0x0000_0080
  - LB off=1 -> 0x0000_007F
  - LH off=2 -> 0xFFFF_8180
  - LHU off=2 -> 0x0000_8180
- x0 suppression: ALU rd=0 and load rd=0 -> no RegWEn pulse, pend_cnt unchanged, alu_ready stays 1.
